kernel_st_adaptor_unpacker: RTL
===============================

# kernel_st_adaptor_unpacker

Streaming word-to-symbol unpacker on the read side of the kernel ST adaptor FIFO. Accepts 36-bit packed words (32 data bits, SOP, EOP, 2-bit empty) over a ready/valid sink with ready latency 0. Emits them as a stream of 8-bit symbols with per-symbol SOP/EOP over a ready/valid source. Drains the FIFO output directly, at full symbol rate, with no bubble between words.

## Interface
- SYMBOLS_PER_WORD, 4, symbols per input word; fixed at 4.
- SYMBOL_WIDTH, 8, bits per output symbol.
- EMPTY_WIDTH, 2, width of the empty field; log2(SYMBOLS_PER_WORD).
- IN_WIDTH, 36, input word width; SYMBOLS_PER_WORD*SYMBOL_WIDTH + 2 + EMPTY_WIDTH.
- clk  input  1  single clock; all state on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- in_ready  output  1  sink ready, ready latency 0.
- in_valid  input  1  sink valid.
- in_data  input  36  [35]=SOP, [34]=EOP, [33:32]=empty, [31:0]=data; symbol 0 in [31:24] (big-endian).
- out_ready  input  1  source ready, ready latency 0.
- out_valid  output  1  source valid.
- out_data  output  8  current symbol.
- out_sop  output  1  start of packet; asserted on the first symbol only.
- out_eop  output  1  end of packet; asserted on the last valid symbol only.
- busy  output  1  high while a word is held (equal to out_valid).

## Operation
- State: one holding register (hold_word, 36 bits), hold_valid flag, 2-bit symbol index idx.
- Definitions:
  - last_idx = hold_word[34] ? (3 - hold_word[33:32]) : 3.
  - last = (idx == last_idx).
  - out_xfer = out_valid && out_ready.
  - in_xfer = in_valid && in_ready.
- in_ready = !hold_valid || (out_xfer && last). This is combinational from out_ready.
- out_valid = hold_valid.
- out_data = hold_word[31-8*idx -: 8].
- out_sop = hold_word[35] && (idx == 0).
- out_eop = hold_word[34] && last.
- On out_xfer && !last: idx <= idx + 1.
- On out_xfer && last: idx <= 0. hold_valid <= 0 unless in_xfer happens in the same cycle.
- On in_xfer: hold_word <= in_data, hold_valid <= 1, idx <= 0. This covers a load while idle and a reload in the same cycle as the last symbol.
- Empty field:
  - Ignored when EOP=0; the full 4 symbols are emitted.
  - When EOP=1, symbols after last_idx are never presented.
- A word with SOP=1, EOP=1, empty=3 emits one symbol with out_sop=out_eop=1.
- Data lanes are not checked. SOP/EOP sequencing errors from upstream pass through unchanged.
- Reset (async, while reset_n=0):
  - hold_valid=0, idx=0, hold_word=0.
  - out_valid=0, out_sop=0, out_eop=0, out_data=0, busy=0.
  - in_ready=1, but in_valid is ignored until reset_n deasserts.
- Reset mid-word discards the held word and any unsent symbols.

## Timing
- Latency: a word accepted at edge N presents symbol 0 in the cycle after edge N.
- Throughput: 1 symbol/cycle with out_ready held high. A full word takes 4 cycles, an EOP word takes 4-empty cycles.
- Back-to-back words: the next word loads on the same edge the last symbol transfers, so symbol 0 of the next word follows with zero bubble.
- Back-pressure: out_ready=0 holds out_data, out_sop, out_eop and idx stable. in_ready stays 0 while a word is held.
- out_valid is never dropped without an out_xfer on the last symbol.
- in_ready may rise combinationally within a cycle when out_ready rises on the last symbol. The upstream FIFO tolerates this.
- idx wrap: it reaches at most 3 and returns to 0 only via last or via a load.

## Test plan
- Reset with out_ready=1, then send word 0x8_AABBCCDD (SOP=1, EOP=0) and 0x4_11223344 (EOP=1, empty=0) back-to-back.
  - Required: symbols AA,BB,CC,DD,11,22,33,44 on 8 consecutive cycles.
  - out_sop only on AA, out_eop only on 44.
  - in_ready high exactly on the edge DD and 44 transfer.
- Send 0x6_DEADBEEF (EOP=1, empty=2).
  - Required: DE, then AD with out_eop=1, and 2 cycles of out_valid only.
  - in_ready=1 on the AD cycle.
- Send 0xF_5A000000 (SOP=1, EOP=1, empty=3).
  - Required: a single symbol 5A with out_sop=out_eop=1, then out_valid=0.
- Send 0x0_01020304 (no SOP/EOP), hold out_ready=0 for 5 cycles after symbol 02 appears, then release.
  - Required: 02 stable with out_valid=1 for those 5 cycles.
  - in_ready=0 throughout.
  - 03, 04 follow, with no duplicate or lost symbol.
- Assert reset_n=0 for 1 cycle after symbol BB of a held word.
  - Required: out_valid=0 immediately and in_ready=1.
  - After release, the next word 0x8_10203040 starts cleanly at symbol 10 with out_sop=1.
- Random test, 500 words, random in_valid/out_ready from a FIFO model.
  - Required: the output symbol stream equals the reference unpacking of the input words.
  - SOP/EOP counts match the packet count.

Source files
------------

// File: rtl/kernel_st_adaptor_unpacker.sv
// -----------------------------------------------------------------------------
// kernel_st_adaptor_unpacker
//
// Purpose:
//   Read-side unpacker for the kernel ST adaptor FIFO. It takes one packed
//   36-bit word per transfer (32 data bits plus SOP, EOP and a 2-bit empty
//   count) and replays it as a stream of 8-bit symbols. Symbol 0 is the most
//   significant byte. When the last symbol of a word transfers, the next word
//   is loaded on the same edge, so the stream runs at one symbol per cycle
//   with no bubble between words.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   reset_n    asynchronous active-low reset
//   in_ready   sink ready (ready latency 0), combinational from out_ready
//   in_valid   sink valid
//   in_data    [35]=SOP, [34]=EOP, [33:32]=empty, [31:0]=data
//   out_ready  source ready (ready latency 0)
//   out_valid  source valid
//   out_data   current symbol
//   out_sop    start of packet, on symbol 0 of a SOP word
//   out_eop    end of packet, on the last valid symbol of an EOP word
//   busy       high while a word is held (same as out_valid)
// -----------------------------------------------------------------------------
module kernel_st_adaptor_unpacker #(
    parameter int SYMBOLS_PER_WORD = 4,
    parameter int SYMBOL_WIDTH     = 8,
    parameter int EMPTY_WIDTH      = 2,
    parameter int IN_WIDTH         = SYMBOLS_PER_WORD * SYMBOL_WIDTH + 2 + EMPTY_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic                    in_ready,
    input  logic                    in_valid,
    input  logic [IN_WIDTH-1:0]     in_data,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [SYMBOL_WIDTH-1:0] out_data,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic                    busy
);

    localparam int DATA_WIDTH = SYMBOLS_PER_WORD * SYMBOL_WIDTH;
    localparam int SOP_BIT    = IN_WIDTH - 1;
    localparam int EOP_BIT    = IN_WIDTH - 2;
    localparam logic [EMPTY_WIDTH-1:0] MAX_IDX = EMPTY_WIDTH'(SYMBOLS_PER_WORD - 1);

    logic [IN_WIDTH-1:0]    hold_word_reg, hold_word_next;
    logic                   hold_valid_reg, hold_valid_next;
    logic [EMPTY_WIDTH-1:0] idx_reg, idx_next;

    logic [SYMBOL_WIDTH-1:0] sym [SYMBOLS_PER_WORD];
    logic [EMPTY_WIDTH-1:0]  last_idx;
    logic                    last;
    logic                    out_xfer;
    logic                    in_xfer;

    // Big-endian lane split: symbol 0 lives in the top byte of the data field.
    generate
        for (genvar gi = 0; gi < SYMBOLS_PER_WORD; gi++) begin : g_lane
            assign sym[gi] = hold_word_reg[DATA_WIDTH-1-gi*SYMBOL_WIDTH -: SYMBOL_WIDTH];
        end
    endgenerate

    // The empty count only trims the tail of an EOP word; on other words it
    // is ignored and all symbols are emitted.
    assign last_idx = hold_word_reg[EOP_BIT]
                    ? (MAX_IDX - hold_word_reg[DATA_WIDTH +: EMPTY_WIDTH])
                    : MAX_IDX;
    assign last     = (idx_reg == last_idx);

    assign out_valid = hold_valid_reg;
    assign busy      = hold_valid_reg;
    assign out_xfer  = out_valid && out_ready;

    // Accept a new word when idle, or on the very edge the final symbol
    // leaves, which is what gives zero-bubble back-to-back words.
    assign in_ready  = !hold_valid_reg || (out_xfer && last);
    assign in_xfer   = in_valid && in_ready;

    assign out_data  = sym[idx_reg];
    assign out_sop   = hold_word_reg[SOP_BIT] && (idx_reg == '0);
    assign out_eop   = hold_word_reg[EOP_BIT] && last;

    always_comb begin
        hold_word_next  = hold_word_reg;
        hold_valid_next = hold_valid_reg;
        idx_next        = idx_reg;

        if (out_xfer) begin
            if (last) begin
                idx_next        = '0;
                hold_valid_next = 1'b0;
            end else begin
                idx_next = idx_reg + 1'b1;
            end
        end

        // A load overrides the end-of-word clear above.
        if (in_xfer) begin
            hold_word_next  = in_data;
            hold_valid_next = 1'b1;
            idx_next        = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_word_reg  <= '0;
            hold_valid_reg <= 1'b0;
            idx_reg        <= '0;
        end else begin
            hold_word_reg  <= hold_word_next;
            hold_valid_reg <= hold_valid_next;
            idx_reg        <= idx_next;
        end
    end

endmodule
